// File: rtl/sprite_blitter.sv
// Sprite redraw engine: optionally erases the previous rectangle, then raster-draws
// a SPR_W x SPR_H rectangle one pixel per granted cycle onto a shared VGA writer.
module sprite_blitter #(
  parameter int X_W     = 8,
  parameter int Y_W     = 7,
  parameter int COLOR_W = 3,
  parameter int SPR_W   = 4,
  parameter int SPR_H   = 3
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic [X_W-1:0]     new_x,
  input  logic [Y_W-1:0]     new_y,
  input  logic [COLOR_W-1:0] color_in,
  input  logic               erase_en,
  input  logic               grant,
  output logic               busy,
  output logic               done,
  output logic [X_W-1:0]     x_out,
  output logic [Y_W-1:0]     y_out,
  output logic [COLOR_W-1:0] color_out,
  output logic               writeEn
);

  localparam int CX_W = (SPR_W > 1) ? $clog2(SPR_W) : 1;
  localparam int CY_W = (SPR_H > 1) ? $clog2(SPR_H) : 1;
  localparam logic [CX_W-1:0] CX_LAST = CX_W'(SPR_W - 1);
  localparam logic [CY_W-1:0] CY_LAST = CY_W'(SPR_H - 1);

  typedef enum logic [1:0] {IDLE, ERASE, LOAD, DRAW} state_t;

  state_t             state;
  logic [X_W-1:0]     lat_x, old_x;
  logic [Y_W-1:0]     lat_y, old_y;
  logic [COLOR_W-1:0] lat_color;
  logic               has_old;
  logic [CX_W-1:0]    cx;
  logic [CY_W-1:0]    cy;

  logic               last_px;
  logic [X_W-1:0]     pix_x;
  logic [Y_W-1:0]     pix_y;

  assign busy    = (state != IDLE);
  assign last_px = (cx == CX_LAST) && (cy == CY_LAST);
  // Erase walks the old rectangle, draw walks the new one; coordinates wrap.
  assign pix_x   = ((state == ERASE) ? old_x : lat_x) + X_W'(cx);
  assign pix_y   = ((state == ERASE) ? old_y : lat_y) + Y_W'(cy);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      lat_x     <= '0;
      lat_y     <= '0;
      lat_color <= '0;
      old_x     <= '0;
      old_y     <= '0;
      has_old   <= 1'b0;
      cx        <= '0;
      cy        <= '0;
      x_out     <= '0;
      y_out     <= '0;
      color_out <= '0;
      writeEn   <= 1'b0;
      done      <= 1'b0;
    end else begin
      writeEn <= 1'b0;
      done    <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            lat_x     <= new_x;
            lat_y     <= new_y;
            lat_color <= color_in;
            cx        <= '0;
            cy        <= '0;
            state     <= (erase_en && has_old) ? ERASE : LOAD;
          end
        end
        ERASE, DRAW: begin
          if (grant) begin
            x_out     <= pix_x;
            y_out     <= pix_y;
            color_out <= (state == ERASE) ? '0 : lat_color;
            writeEn   <= 1'b1;
            if (last_px) begin
              cx <= '0;
              cy <= '0;
              if (state == ERASE) begin
                state <= LOAD;
              end else begin
                state   <= IDLE;
                done    <= 1'b1;
                has_old <= 1'b1;
              end
            end else if (cx == CX_LAST) begin
              cx <= '0;
              cy <= cy + CY_W'(1);
            end else begin
              cx <= cx + CX_W'(1);
            end
          end
        end
        LOAD: begin
          old_x <= lat_x;
          old_y <= lat_y;
          cx    <= '0;
          cy    <= '0;
          state <= DRAW;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_blitter.sv
// Bench for sprite_blitter: a pixel-list model of each redraw is checked cycle by
// cycle against a 4x3 instance; an 8x8 instance checks the larger scan length.
module tb_sprite_blitter;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       start = 1'b0;
  logic [7:0] new_x = '0;
  logic [6:0] new_y = '0;
  logic [2:0] color_in = '0;
  logic       erase_en = 1'b0;
  logic       grant = 1'b1;
  logic       busy, done, writeEn;
  logic [7:0] x_out;
  logic [6:0] y_out;
  logic [2:0] color_out;

  logic       start_b = 1'b0;
  logic       erase_b = 1'b0;
  logic       grant_b = 1'b1;
  logic       busy_b, done_b, we_b;
  logic [7:0] x_b;
  logic [6:0] y_b;
  logic [2:0] c_b;

  int vecs = 0;
  int errs = 0;

  typedef struct {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } pix_t;

  pix_t       exp_q[$];
  bit         m_has_old = 0;
  logic [7:0] m_old_x = '0;
  logic [6:0] m_old_y = '0;

  always #5 clk = ~clk;

  sprite_blitter dut (
    .clk(clk), .resetn(resetn), .start(start), .new_x(new_x), .new_y(new_y),
    .color_in(color_in), .erase_en(erase_en), .grant(grant), .busy(busy),
    .done(done), .x_out(x_out), .y_out(y_out), .color_out(color_out), .writeEn(writeEn)
  );

  sprite_blitter #(.SPR_W(8), .SPR_H(8)) dut_b (
    .clk(clk), .resetn(resetn), .start(start_b), .new_x(8'd40), .new_y(7'd30),
    .color_in(3'b110), .erase_en(erase_b), .grant(grant_b), .busy(busy_b),
    .done(done_b), .x_out(x_b), .y_out(y_b), .color_out(c_b), .writeEn(we_b)
  );

  task automatic test_reset;
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy got %b want 0", busy); end
    vecs++; if (writeEn !== 1'b0) begin errs++; $display("FAIL reset_we got %b want 0", writeEn); end
    vecs++; if (done !== 1'b0) begin errs++; $display("FAIL reset_done got %b want 0", done); end
    vecs++; if ({x_out, y_out, color_out} !== 18'd0) begin
      errs++; $display("FAIL reset_pix got %0d,%0d,%0d want 0,0,0", x_out, y_out, color_out);
    end
    vecs++; if (busy_b !== 1'b0) begin errs++; $display("FAIL reset_busy_b got %b want 0", busy_b); end
    @(negedge clk);
    resetn = 1'b1;
    m_has_old = 0; m_old_x = '0; m_old_y = '0;
  endtask

  // gmode: 0 grant held, 1 random grant, 2 grant low for stall_len cycles after pixel stall_at.
  // reset_at > 0 pulls reset after that many draw pixels.
  task automatic run_a(input string nm, input logic [7:0] nx, input logic [6:0] ny,
                       input logic [2:0] col, input logic er, input int gmode,
                       input int stall_at, input int stall_len, input bit mid_start,
                       input int reset_at, input int exp_done_cyc);
    int   n_erase, total, issued, cyc, stall_left;
    bit   loaded, g;
    pix_t p;
    exp_q.delete();
    n_erase = (er && m_has_old) ? 12 : 0;
    if (n_erase != 0)
      for (int yy = 0; yy < 3; yy++)
        for (int xx = 0; xx < 4; xx++) begin
          p.x = m_old_x + 8'(xx); p.y = m_old_y + 7'(yy); p.c = 3'b000;
          exp_q.push_back(p);
        end
    for (int yy = 0; yy < 3; yy++)
      for (int xx = 0; xx < 4; xx++) begin
        p.x = nx + 8'(xx); p.y = ny + 7'(yy); p.c = col;
        exp_q.push_back(p);
      end
    total = exp_q.size();

    new_x = nx; new_y = ny; color_in = col; erase_en = er; start = 1'b1; grant = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    vecs++; if (busy !== 1'b1) begin errs++; $display("FAIL %s start_busy got %b want 1", nm, busy); end

    issued = 0; cyc = 0; stall_left = 0; loaded = 0;
    while (issued < total && cyc < 500) begin
      case (gmode)
        0: g = 1'b1;
        1: g = ($urandom_range(0, 3) != 0);
        default: begin
          if (stall_left > 0) begin g = 1'b0; stall_left--; end
          else g = 1'b1;
        end
      endcase
      grant = g;
      if (mid_start) begin
        start = 1'b1; new_x = 8'($urandom); new_y = 7'($urandom);
        color_in = 3'($urandom); erase_en = 1'b1;
      end
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
      if (!loaded && issued == n_erase) begin
        loaded = 1;
        m_old_x = nx; m_old_y = ny;
        vecs++; if (writeEn !== 1'b0 || done !== 1'b0) begin
          errs++; $display("FAIL %s load_slot we=%b done=%b want 0,0", nm, writeEn, done);
        end
      end else if (g) begin
        p = exp_q[issued];
        issued++;
        vecs++; if (writeEn !== 1'b1 || x_out !== p.x || y_out !== p.y || color_out !== p.c) begin
          errs++; $display("FAIL %s pix%0d got we=%b (%0d,%0d,%0d) want we=1 (%0d,%0d,%0d)",
                           nm, issued, writeEn, x_out, y_out, color_out, p.x, p.y, p.c);
        end
        vecs++; if (done !== (issued == total)) begin
          errs++; $display("FAIL %s done_at_pix%0d got %b want %b", nm, issued, done, issued == total);
        end
        if (issued == total) m_has_old = 1;
        if (gmode == 2 && issued == stall_at) stall_left = stall_len;
        if (reset_at > 0 && issued == n_erase + reset_at) begin
          resetn = 1'b0;
          #1;
          vecs++; if (writeEn !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errs++; $display("FAIL %s async_reset we=%b busy=%b done=%b want 0,0,0",
                             nm, writeEn, busy, done);
          end
          m_has_old = 0; m_old_x = '0; m_old_y = '0;
          @(negedge clk);
          resetn = 1'b1;
          return;
        end
      end else begin
        vecs++; if (writeEn !== 1'b0 || done !== 1'b0) begin
          errs++; $display("FAIL %s stall we=%b done=%b want 0,0", nm, writeEn, done);
        end
      end
    end
    if (cyc >= 500) begin
      errs++; $display("FAIL %s timeout issued %0d want %0d", nm, issued, total);
    end
    if (exp_done_cyc > 0) begin
      vecs++; if (cyc !== exp_done_cyc) begin
        errs++; $display("FAIL %s done_latency got %0d want %0d", nm, cyc, exp_done_cyc);
      end
    end
    grant = 1'b1;
    @(posedge clk); #1;
    vecs++; if (busy !== 1'b0 || writeEn !== 1'b0 || done !== 1'b0) begin
      errs++; $display("FAIL %s idle_after busy=%b we=%b done=%b want 0,0,0", nm, busy, writeEn, done);
    end
  endtask

  task automatic test_no_erase_first;
    run_a("first", 8'd10, 7'd20, 3'b101, 1'b0, 0, 0, 0, 0, 0, 13);
  endtask

  task automatic test_erase;
    run_a("erase", 8'd11, 7'd20, 3'b010, 1'b1, 0, 0, 0, 0, 0, 25);
  endtask

  task automatic test_grant_stall;
    run_a("stall", 8'd12, 7'd21, 3'b011, 1'b1, 2, 5, 3, 0, 0, 28);
  endtask

  task automatic test_wrap_and_busy_start;
    run_a("wrap", 8'd254, 7'd126, 3'b111, 1'b0, 0, 0, 0, 1, 0, 13);
    run_a("wrap_erase", 8'd3, 7'd5, 3'b001, 1'b1, 0, 0, 0, 1, 0, 25);
  endtask

  task automatic test_reset_mid_draw;
    run_a("midreset", 8'd50, 7'd60, 3'b100, 1'b1, 0, 0, 0, 0, 6, 0);
    run_a("after_reset", 8'd70, 7'd80, 3'b110, 1'b1, 0, 0, 0, 0, 0, 13);
  endtask

  task automatic test_random;
    for (int i = 0; i < 8; i++)
      run_a("rand", 8'($urandom), 7'($urandom), 3'($urandom), 1'($urandom), 1, 0, 0,
            1'($urandom), 0, 0);
  endtask

  task automatic run_b(input logic er, output int n_erase, output int n_draw, output int dcyc);
    int cyc;
    n_erase = 0; n_draw = 0; dcyc = 0; cyc = 0;
    erase_b = er; start_b = 1'b1; grant_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    while (dcyc == 0 && cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
      if (we_b && c_b == 3'b000) n_erase++;
      if (we_b && c_b == 3'b110) n_draw++;
      if (done_b) dcyc = cyc;
    end
    if (dcyc == 0) begin errs++; $display("FAIL big_timeout cycles %0d want done", cyc); end
  endtask

  task automatic test_big_sprite;
    int ne, nd, dc;
    run_b(1'b1, ne, nd, dc);
    vecs++; if (ne !== 0 || nd !== 64 || dc !== 65) begin
      errs++; $display("FAIL big_first erase=%0d draw=%0d done=%0d want 0,64,65", ne, nd, dc);
    end
    @(posedge clk); #1;
    run_b(1'b1, ne, nd, dc);
    vecs++; if (ne !== 64 || nd !== 64) begin
      errs++; $display("FAIL big_writes erase=%0d draw=%0d want 64,64", ne, nd);
    end
    vecs++; if (dc !== 129) begin errs++; $display("FAIL big_done got %0d want 129", dc); end
  endtask

  initial begin
    test_reset();
    test_big_sprite();
    test_no_erase_first();
    test_erase();
    test_grant_stall();
    test_wrap_and_busy_start();
    test_reset_mid_draw();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/sprite_blitter.md
Name: sprite_blitter

Overview:
Parametrised sprite redraw engine for the VGA path. On a start request it erases the sprite's previous rectangle (black pixels), latches the new position, then draws a SPR_W x SPR_H rectangle in the requested colour, one pixel per granted cycle. It replaces the fixed 4x3 serpentine player drawer with a configurable size and a raster scan. It adds a start/done handshake, an optional erase and a write-grant input, so several instances can share one VGA writer through an external arbiter.

Parameters:
X_W, 8, x coordinate width
Y_W, 7, y coordinate width
COLOR_W, 3, colour width
SPR_W, 4, sprite width in pixels (>=1)
SPR_H, 3, sprite height in pixels (>=1)

Ports:
clk  in  1  clock
resetn  in  1  reset; asynchronous, active-low
start  in  1  request redraw; sampled only when busy=0
new_x  in  X_W  new top-left x, latched with start
new_y  in  Y_W  new top-left y, latched with start
color_in  in  COLOR_W  draw colour, latched with start
erase_en  in  1  1 = erase previous rectangle first; latched with start
grant  in  1  arbiter permission to issue one pixel this cycle
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse, coincident with last drawn pixel
x_out  out  X_W  pixel x (registered)
y_out  out  Y_W  pixel y (registered)
color_out  out  COLOR_W  pixel colour (registered)
writeEn  out  1  pixel valid/write strobe (registered)

Behaviour:
- Async reset (resetn=0): state IDLE; old_x/old_y=0; has_old=0; x_out, y_out, color_out, writeEn, done=0; scan counters=0. Takes effect immediately, including mid-operation. The interrupted sprite is not erased later.
- States: IDLE, ERASE, LOAD, DRAW. busy = (state != IDLE), Moore.
- IDLE: start=1 latches new_x, new_y, color_in, erase_en and clears the counters.
  - Go to ERASE if erase_en=1 and has_old=1; otherwise go to LOAD.
  - start while busy=1 is ignored, with no queueing.
- Scan: cx runs 0..SPR_W-1 fastest, cy runs 0..SPR_H-1. Counters advance only on cycles where grant=1. Width is clog2 of the dimension, min 1.
- Issuing a pixel: in ERASE/DRAW with grant=1, at the next edge the block registers x_out=base_x+cx and y_out=base_y+cy (modulo 2^X_W / 2^Y_W, i.e. wrap-around, no clipping) and sets writeEn=1.
  - ERASE: colour 0, base = old position.
  - DRAW: colour = latched colour, base = latched new position.
- grant=0: counters hold and the next-cycle writeEn=0. Otherwise x_out, y_out and color_out hold their last values.
- ERASE exits to LOAD on the edge that issues pixel (SPR_W-1, SPR_H-1).
- LOAD (1 cycle, no write): old_x/old_y <= latched new position; counters cleared; goes to DRAW.
- DRAW: on the edge issuing the last pixel, done<=1 (high exactly one cycle, alongside that pixel's writeEn) and has_old<=1. State returns to IDLE.
- With start sampled at edge t0 and grant held high, the last pixel and done appear after edge:
  - t0+2*SPR_W*SPR_H+1 with erase;
  - t0+SPR_W*SPR_H+1 without erase.
  - Each grant=0 cycle in ERASE/DRAW adds one cycle.
- The first pixel's writeEn is high after edge t0+1 (erase) or t0+2 (no erase).
- erase_en=0 still updates old_x/old_y in LOAD.

Test Plan:
- Reset, then start with (10,20), colour 3'b101, grant=1, defaults → no erase. 12 writes colour 101 in order (10,20),(11,20),(12,20),(13,20),(10,21)…(13,22). done high with the 12th write, 13 cycles after start. busy=0 next cycle.
- Then start with (11,20), colour 3'b010, erase_en=1 → 12 writes colour 000 over x 10..13, y 20..22, then 1 cycle with writeEn=0, then 12 writes colour 010 over x 11..14. done 25 cycles after start.
- Same as the previous scenario, but grant=0 for 3 cycles after the 5th erase pixel → writeEn=0 for those cycles. The pixel sequence is unchanged and done is delayed to 28 cycles.
- start with new_x=254, new_y=126 → x_out sequence 254,255,0,1 and y 126,127,0 (wrap). Asserting start mid-draw is ignored.
- Assert resetn=0 at draw pixel 6 → writeEn, busy and done go 0 immediately (async). The next start with erase_en=1 does no erase (has_old=0).
- Instance with SPR_W=8, SPR_H=8 → 64 erase + 64 draw writes, done 129 cycles after start with grant held.
